// File: rtl/sram_controller.sv
// sram_controller: serves 32-bit MEM-stage loads/stores from a 16-bit
// asynchronous SRAM as two half-word accesses (low half, then high half),
// each held for WAIT_CYCLES+1 cycles. `ready` is low while an access is in
// flight, so the pipeline freezes on !ready.
//
// Handshake: the pipeline raises wr_en/rd_en and holds the request steady
// until it sees ready=1 (the DONE cycle). A request is accepted only in IDLE.
// In DONE the inputs still show the completed request and are ignored. The
// next request is taken in the following IDLE cycle.
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Counter value on the final cycle of each half-word phase.
    localparam logic [2:0] LP_LAST = 3'(WAIT_CYCLES);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [16:0] r_widx;
    logic [31:0] r_wdata;
    logic        r_is_write;
    logic [31:0] r_read_data;

    logic        w_req;
    logic [16:0] w_widx;

    assign w_req     = wr_en | rd_en;
    // Word index of the byte address relative to BASE_ADDR; the subtraction
    // wraps and the byte offset / upper bits are simply dropped.
    assign w_widx    = 17'((address - 32'(BASE_ADDR)) >> 2);
    assign read_data = r_read_data;

    // Access sequencer: capture the request, walk LOW -> HIGH -> DONE,
    // and latch read half-words on the last cycle of each phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_widx      <= 17'd0;
            r_wdata     <= 32'd0;
            r_is_write  <= 1'b0;
            r_read_data <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 3'd0;
                    if (w_req) begin
                        r_widx     <= w_widx;
                        r_wdata    <= write_data;
                        r_is_write <= wr_en;
                        r_state    <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (r_cnt == LP_LAST) begin
                        if (!r_is_write) begin
                            r_read_data[15:0] <= sram_dq_in;
                        end
                        r_cnt   <= 3'd0;
                        r_state <= S_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_HIGH: begin
                    if (r_cnt == LP_LAST) begin
                        if (!r_is_write) begin
                            r_read_data[31:16] <= sram_dq_in;
                        end
                        r_cnt   <= 3'd0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ready: low from the moment a request appears in IDLE until DONE.
    always_comb begin
        ready = 1'b0;
        case (r_state)
            S_IDLE: ready = !w_req;
            S_DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // SRAM pin decode from registered state only (no request-input path).
    always_comb begin
        sram_addr   = 18'd0;
        sram_dq_out = 16'd0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (r_state)
            S_LOW: begin
                sram_addr = {r_widx, 1'b0};
                if (r_is_write) begin
                    sram_dq_out = r_wdata[15:0];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
            end
            S_HIGH: begin
                sram_addr = {r_widx, 1'b1};
                if (r_is_write) begin
                    sram_dq_out = r_wdata[31:16];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
            end
            default: begin
                sram_addr   = 18'd0;
                sram_dq_out = 16'd0;
                sram_dq_oe  = 1'b0;
                sram_we_n   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// Testbench for sram_controller: directed cases followed by randomized
// loads/stores, checked cycle by cycle against a word-level memory model.
// The SRAM pad model commits a half-word only after the write strobe has
// been held on that address for a full phase (a minimum write-pulse width),
// so an aborted half-word write leaves the cell unchanged.
module tb_sram_controller;

    localparam int BASE       = 1024;
    localparam int WAIT       = 1;
    localparam int N          = WAIT + 1;
    localparam int SRAM_WORDS = 262144;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] sram_mem [0:SRAM_WORDS-1];
    logic [31:0] ref_words [int];
    logic [31:0] last_rd;

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Initial SRAM content: a fixed per-half-word pattern.
    function automatic logic [15:0] pat(input logic [17:0] h);
        return h[15:0] ^ 16'hA5A5 ^ {14'd0, h[17:16]};
    endfunction

    // Word-level reference read: last stored word, else the initial pattern.
    function automatic logic [31:0] ref_read(input logic [16:0] w);
        if (ref_words.exists(int'(w))) return ref_words[int'(w)];
        return {pat({w, 1'b1}), pat({w, 1'b0})};
    endfunction

    // Asynchronous SRAM pad model.
    assign sram_dq_in = sram_mem[sram_addr];

    initial begin
        logic [17:0] p_addr;
        logic [15:0] p_data;
        int          p_cnt;
        bit          p_valid;
        for (int i = 0; i < SRAM_WORDS; i++) sram_mem[i] = pat(18'(i));
        p_addr = 18'd0; p_data = 16'd0; p_cnt = 0; p_valid = 1'b0;
        forever begin
            @(posedge clk);
            if (!sram_we_n && sram_dq_oe) begin
                if (p_valid && p_addr == sram_addr && p_data == sram_dq_out) begin
                    p_cnt++;
                end else begin
                    if (p_valid && p_cnt >= N) sram_mem[p_addr] = p_data;
                    p_valid = 1'b1; p_addr = sram_addr; p_data = sram_dq_out; p_cnt = 1;
                end
            end else begin
                if (p_valid && p_cnt >= N) sram_mem[p_addr] = p_data;
                p_valid = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle_pins(input string tag);
        check_eq({tag, "_addr"}, 32'(sram_addr), 32'd0);
        check_eq({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
        check_eq({tag, "_oe"},   32'(sram_dq_oe), 32'd0);
        check_eq({tag, "_dq"},   32'(sram_dq_out), 32'd0);
    endtask

    // One full access, entered at a negedge with the DUT in IDLE; returns at
    // the negedge of the following IDLE cycle. keep=1 leaves the request
    // asserted through DONE (back-to-back), so the caller must follow with
    // another access.
    task automatic do_access(input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [31:0] data, input bit keep);
        logic [16:0] w;
        logic [31:0] exp_rd;
        w = 17'((addr - 32'(BASE)) >> 2);
        wr_en = wr; rd_en = rd; address = addr; write_data = data;
        #1;
        check_eq("req_ready", 32'(ready), 32'd0);
        check_idle_pins("req");
        if (wr) begin
            exp_rd = last_rd;
            ref_words[int'(w)] = data;
        end else begin
            exp_rd  = ref_read(w);
            last_rd = exp_rd;
        end
        for (int k = 1; k <= 2 * N + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k <= 2 * N) begin
                check_eq("busy_ready", 32'(ready), 32'd0);
                check_eq("addr", 32'(sram_addr), 32'({w, (k > N) ? 1'b1 : 1'b0}));
                check_eq("we_n", 32'(sram_we_n), wr ? 32'd0 : 32'd1);
                check_eq("oe",   32'(sram_dq_oe), wr ? 32'd1 : 32'd0);
                if (wr) check_eq("dq_out", 32'(sram_dq_out),
                                 (k > N) ? 32'(data[31:16]) : 32'(data[15:0]));
            end else begin
                check_eq("done_ready", 32'(ready), 32'd1);
                check_idle_pins("done");
                check_eq("read_data", read_data, exp_rd);
            end
        end
        if (!keep) begin
            wr_en = 1'b0; rd_en = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("idle_ready", 32'(ready), keep ? 32'd0 : 32'd1);
        check_idle_pins("idle");
        check_eq("idle_rdata", read_data, exp_rd);
    endtask

    initial begin
        logic [16:0] w;
        logic [31:0] old;
        int          n_rand;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b1; address = 32'd1032; write_data = 32'd0;
        last_rd = 32'd0;

        // Reset held 3 cycles with a load pending: FSM must stay in IDLE.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("rst_rdata", read_data, 32'd0);
            check_eq("rst_ready", 32'(ready), 32'd0);
            check_idle_pins("rst");
        end
        rd_en = 1'b0;
        #1;
        check_eq("rst_ready_norq", 32'(ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Store, load back, simultaneous rd+wr, address wrap.
        do_access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0);
        do_access(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0);
        check_eq("load_value", last_rd, 32'hDEADBEEF);
        do_access(1'b1, 1'b1, 32'd1040, 32'h12345678, 1'b0);
        do_access(1'b0, 1'b1, 32'd0, 32'd0, 1'b0);

        // Reset during the first HIGH cycle of a store to the same word.
        w = 17'((32'd1032 - 32'(BASE)) >> 2);
        old = ref_read(w);
        wr_en = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
        for (int k = 1; k <= N + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("abort_addr", 32'(sram_addr), 32'({w, 1'b1}));
        rst = 1'b0; wr_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_ready", 32'(ready), 32'd1);
        check_eq("abort_rdata", read_data, 32'd0);
        check_idle_pins("abort");
        rst = 1'b1;
        ref_words[int'(w)] = {old[31:16], 16'hF00D};
        last_rd = 32'd0;
        do_access(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0);
        check_eq("abort_load", last_rd, 32'hDEADF00D);

        // Randomized traffic, biased toward a small set of words for reuse.
        n_rand = 40;
        for (int i = 0; i < n_rand; i++) begin
            int          op;
            logic [31:0] a;
            bit          kp;
            op = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else a = 32'(BASE) + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
            kp = (i != n_rand - 1) && ($urandom_range(0, 1) == 1);
            do_access(op != 0, op != 1, a, $urandom, kp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
